ycr_sleep_ctrl: RTL and testbench

//  Core-side WFI sleep/wakeup handshake controller; the core end of the per-core clock-gate link.
//  On WFI it stalls the pipeline, drains outstanding bus traffic, then asserts sleep_o (drives the

---
 rtl/ycr_sleep_ctrl.sv | 149 ++++++++++++++
 tb/tb_ycr_sleep_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ycr_sleep_ctrl.sv
// WFI sleep/wakeup controller: RUN->DRAIN->SLEEP->WAKE->RUN; wfi_req->sleep_o 2 cycles, wake->resume_o WAKE_DLY+1.
// No backpressure: inputs sampled every clock, all outputs registered; wfi_req outside RUN is dropped.
module ycr_sleep_ctrl #(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned DRAIN_TMO = 64,
  parameter int unsigned WAKE_DLY  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wfi_req,
  input  logic             sleep_en,
  input  logic             irq_pending,
  input  logic             dbg_halt_req,
  input  logic [CNT_W-1:0] outst_cnt,
  input  logic             fetch_idle,
  input  logic             wakeup_i,
  output logic             stall_o,
  output logic             sleep_o,
  output logic             resume_o,
  output logic             drain_tmo_o,
  output logic [15:0]      sleep_cnt_o,
  output logic [1:0]       state_o
);

  localparam int unsigned TMR_W = $clog2(DRAIN_TMO + 1);
  localparam int unsigned WK_W  = $clog2(WAKE_DLY + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [WK_W-1:0]    wk_q, wk_d;
  logic [15:0]        sleep_cnt_q, sleep_cnt_d;
  logic               stall_q, stall_d;
  logic               sleep_q, sleep_d;
  logic               resume_q, resume_d;
  logic               tmo_q, tmo_d;

  logic               wake_evt;
  logic               drained;

  assign wake_evt = irq_pending | dbg_halt_req;
  assign drained  = (outst_cnt == '0) & fetch_idle;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    wk_d        = wk_q;
    sleep_cnt_d = sleep_cnt_q;
    resume_d    = 1'b0;
    tmo_d       = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (wfi_req) begin
          if (sleep_en && !wake_evt) begin
            state_d = ST_DRAIN;
            tmr_d   = '0;
          end else begin
            // WFI treated as a NOP still owes the pipeline its resume pulse
            resume_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        tmr_d = tmr_q + 1'b1;
        if (wake_evt) begin
          state_d = ST_WAKE;
          wk_d    = '0;
        end else if (drained) begin
          state_d = ST_SLEEP;
          if (sleep_cnt_q != 16'hFFFF) begin
            sleep_cnt_d = sleep_cnt_q + 16'd1;
          end
        end else if (tmr_q == TMR_W'(DRAIN_TMO - 1)) begin
          state_d = ST_WAKE;
          wk_d    = '0;
          tmo_d   = 1'b1;
        end
      end

      ST_SLEEP: begin
        // Holds purely on register state, so arbitrary clock gaps are harmless
        if (wakeup_i || wake_evt) begin
          state_d = ST_WAKE;
          wk_d    = '0;
        end
      end

      ST_WAKE: begin
        if (wk_q == WK_W'(WAKE_DLY - 1)) begin
          state_d  = ST_RUN;
          resume_d = 1'b1;
        end else begin
          wk_d = wk_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    stall_d = (state_d != ST_RUN);
    sleep_d = (state_d == ST_SLEEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      tmr_q       <= '0;
      wk_q        <= '0;
      sleep_cnt_q <= '0;
      stall_q     <= 1'b0;
      sleep_q     <= 1'b0;
      resume_q    <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      wk_q        <= wk_d;
      sleep_cnt_q <= sleep_cnt_d;
      stall_q     <= stall_d;
      sleep_q     <= sleep_d;
      resume_q    <= resume_d;
      tmo_q       <= tmo_d;
    end
  end

  assign stall_o     = stall_q;
  assign sleep_o     = sleep_q;
  assign resume_o    = resume_q;
  assign drain_tmo_o = tmo_q;
  assign sleep_cnt_o = sleep_cnt_q;
  assign state_o     = state_q;

`ifndef SYNTHESIS
  a_resume_unstalled : assert property (@(posedge clk) disable iff (rst) resume_o |-> !stall_o);
  a_sleep_stalled    : assert property (@(posedge clk) disable iff (rst) sleep_o |-> stall_o);
  a_tmo_one_cycle    : assert property (@(posedge clk) disable iff (rst) drain_tmo_o |=> !drain_tmo_o);
`endif

endmodule

// File: tb/tb_ycr_sleep_ctrl.sv
// Directed bench for ycr_sleep_ctrl with default parameters (CNT_W=4, DRAIN_TMO=64, WAKE_DLY=2).
module tb_ycr_sleep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wfi_req;
  logic        sleep_en;
  logic        irq_pending;
  logic        dbg_halt_req;
  logic [3:0]  outst_cnt;
  logic        fetch_idle;
  logic        wakeup_i;
  logic        stall_o;
  logic        sleep_o;
  logic        resume_o;
  logic        drain_tmo_o;
  logic [15:0] sleep_cnt_o;
  logic [1:0]  state_o;

  int n_chk  = 0;
  int n_fail = 0;

  ycr_sleep_ctrl #(.CNT_W(4), .DRAIN_TMO(64), .WAKE_DLY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .wfi_req      (wfi_req),
    .sleep_en     (sleep_en),
    .irq_pending  (irq_pending),
    .dbg_halt_req (dbg_halt_req),
    .outst_cnt    (outst_cnt),
    .fetch_idle   (fetch_idle),
    .wakeup_i     (wakeup_i),
    .stall_o      (stall_o),
    .sleep_o      (sleep_o),
    .resume_o     (resume_o),
    .drain_tmo_o  (drain_tmo_o),
    .sleep_cnt_o  (sleep_cnt_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; wfi_req = 1'b0; sleep_en = 1'b1; irq_pending = 1'b0; dbg_halt_req = 1'b0;
    outst_cnt = 4'd0; fetch_idle = 1'b1; wakeup_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    n_chk++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL rst_init_state got=%0d exp=0", state_o); end
    n_chk++; if ({stall_o, sleep_o, resume_o, drain_tmo_o} !== 4'b0000) begin n_fail++; $display("FAIL rst_init_outs got=%b exp=0000", {stall_o, sleep_o, resume_o, drain_tmo_o}); end
    n_chk++; if (sleep_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_init_cnt got=%h exp=0000", sleep_cnt_o); end
    wfi_req = 1'b1; tick(); wfi_req = 1'b0; tick();
    n_chk++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL rst_reach_sleep got=%0d exp=2", state_o); end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_chk++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL rst_sleep_state got=%0d exp=0", state_o); end
    n_chk++; if ({stall_o, sleep_o, resume_o} !== 3'b000) begin n_fail++; $display("FAIL rst_sleep_outs got=%b exp=000", {stall_o, sleep_o, resume_o}); end
    n_chk++; if (sleep_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_sleep_cnt got=%h exp=0000", sleep_cnt_o); end
    tick();
    n_chk++; if (resume_o !== 1'b0) begin n_fail++; $display("FAIL rst_no_resume got=%b exp=0", resume_o); end
  endtask

  task automatic test_nominal;
    wfi_req = 1'b1; tick(); wfi_req = 1'b0;
    n_chk++; if ({state_o, stall_o, sleep_o} !== 4'b01_1_0) begin n_fail++; $display("FAIL nom_drain got=%b exp=0110", {state_o, stall_o, sleep_o}); end
    tick();
    n_chk++; if ({state_o, stall_o, sleep_o} !== 4'b10_1_1) begin n_fail++; $display("FAIL nom_sleep got=%b exp=1011", {state_o, stall_o, sleep_o}); end
    n_chk++; if (sleep_cnt_o !== 16'd1) begin n_fail++; $display("FAIL nom_cnt got=%h exp=0001", sleep_cnt_o); end
    wfi_req = 1'b1; tick(); wfi_req = 1'b0; tick(); tick();
    n_chk++; if (sleep_o !== 1'b1 || state_o !== 2'd2) begin n_fail++; $display("FAIL nom_hold got=%b/%0d exp=1/2", sleep_o, state_o); end
    wakeup_i = 1'b1; tick(); wakeup_i = 1'b0;
    n_chk++; if ({state_o, stall_o, sleep_o, resume_o} !== 5'b11_1_0_0) begin n_fail++; $display("FAIL nom_wake1 got=%b exp=11100", {state_o, stall_o, sleep_o, resume_o}); end
    tick();
    n_chk++; if ({state_o, resume_o} !== 3'b11_0) begin n_fail++; $display("FAIL nom_wake2 got=%b exp=110", {state_o, resume_o}); end
    tick();
    n_chk++; if ({state_o, stall_o, resume_o} !== 4'b00_0_1) begin n_fail++; $display("FAIL nom_resume got=%b exp=0001", {state_o, stall_o, resume_o}); end
    tick();
    n_chk++; if (resume_o !== 1'b0) begin n_fail++; $display("FAIL nom_resume_once got=%b exp=0", resume_o); end
    n_chk++; if (sleep_cnt_o !== 16'd1) begin n_fail++; $display("FAIL nom_cnt_after got=%h exp=0001", sleep_cnt_o); end
  endtask

  task automatic test_nop;
    for (int k = 0; k < 3; k++) begin
      sleep_en     = (k != 0);
      irq_pending  = (k == 1);
      dbg_halt_req = (k == 2);
      wfi_req = 1'b1; tick(); wfi_req = 1'b0;
      n_chk++; if ({state_o, stall_o, resume_o} !== 4'b00_0_1) begin n_fail++; $display("FAIL nop_resume_%0d got=%b exp=0001", k, {state_o, stall_o, resume_o}); end
      tick();
      n_chk++; if ({stall_o, resume_o} !== 2'b00) begin n_fail++; $display("FAIL nop_after_%0d got=%b exp=00", k, {stall_o, resume_o}); end
    end
    sleep_en = 1'b1; irq_pending = 1'b0; dbg_halt_req = 1'b0;
  endtask

  task automatic test_drain;
    int bad;
    outst_cnt = 4'd3;
    wfi_req = 1'b1; tick(); wfi_req = 1'b0;
    bad = 0;
    for (int i = 2; i <= 11; i++) begin
      tick();
      if (i == 11) outst_cnt = 4'd0;
      if (state_o !== 2'd1 || sleep_o !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL drain_wait bad_cycles=%0d exp=0", bad); end
    tick();
    n_chk++; if (sleep_o !== 1'b1 || sleep_cnt_o !== 16'd2) begin n_fail++; $display("FAIL drain_sleep got=%b/%h exp=1/0002", sleep_o, sleep_cnt_o); end
    wakeup_i = 1'b1; tick(); wakeup_i = 1'b0; tick(); tick();
    n_chk++; if (resume_o !== 1'b1) begin n_fail++; $display("FAIL drain_resume got=%b exp=1", resume_o); end

    outst_cnt = 4'd2;
    wfi_req = 1'b1; tick(); wfi_req = 1'b0;
    bad = 0;
    for (int i = 2; i <= 64; i++) begin
      tick();
      if (state_o !== 2'd1 || drain_tmo_o !== 1'b0 || resume_o !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL tmo_wait bad_cycles=%0d exp=0", bad); end
    tick();
    n_chk++; if ({state_o, drain_tmo_o, sleep_o} !== 4'b11_1_0) begin n_fail++; $display("FAIL tmo_pulse got=%b exp=1110", {state_o, drain_tmo_o, sleep_o}); end
    tick();
    n_chk++; if ({state_o, drain_tmo_o} !== 3'b11_0) begin n_fail++; $display("FAIL tmo_once got=%b exp=110", {state_o, drain_tmo_o}); end
    tick();
    n_chk++; if ({state_o, stall_o, resume_o} !== 4'b00_0_1) begin n_fail++; $display("FAIL tmo_resume got=%b exp=0001", {state_o, stall_o, resume_o}); end
    n_chk++; if (sleep_cnt_o !== 16'd2) begin n_fail++; $display("FAIL tmo_cnt got=%h exp=0002", sleep_cnt_o); end
    tick();
  endtask

  task automatic test_simultaneous;
    outst_cnt = 4'd2;
    wfi_req = 1'b1; tick(); wfi_req = 1'b0; tick(); tick();
    outst_cnt = 4'd0; irq_pending = 1'b1;
    tick();
    n_chk++; if ({state_o, sleep_o} !== 3'b11_0) begin n_fail++; $display("FAIL simul_abort got=%b exp=110", {state_o, sleep_o}); end
    tick(); tick();
    n_chk++; if ({state_o, resume_o} !== 3'b00_1) begin n_fail++; $display("FAIL simul_resume got=%b exp=001", {state_o, resume_o}); end
    n_chk++; if (sleep_cnt_o !== 16'd2) begin n_fail++; $display("FAIL simul_cnt got=%h exp=0002", sleep_cnt_o); end
    irq_pending = 1'b0; tick();
  endtask

  task automatic test_sleep_exits;
    // debug halt pulls the core out of SLEEP
    wfi_req = 1'b1; tick(); wfi_req = 1'b0; tick();
    dbg_halt_req = 1'b1; tick(); dbg_halt_req = 1'b0;
    n_chk++; if ({state_o, sleep_o} !== 3'b11_0) begin n_fail++; $display("FAIL dbg_exit got=%b exp=110", {state_o, sleep_o}); end
    tick(); tick();
    n_chk++; if (resume_o !== 1'b1 || sleep_cnt_o !== 16'd3) begin n_fail++; $display("FAIL dbg_resume got=%b/%h exp=1/0003", resume_o, sleep_cnt_o); end
    // wakeup already high on entry leaves SLEEP after one cycle
    wakeup_i = 1'b1;
    wfi_req = 1'b1; tick(); wfi_req = 1'b0; tick();
    n_chk++; if (sleep_o !== 1'b1) begin n_fail++; $display("FAIL wk_early_sleep got=%b exp=1", sleep_o); end
    tick();
    n_chk++; if ({state_o, sleep_o} !== 3'b11_0) begin n_fail++; $display("FAIL wk_early_exit got=%b exp=110", {state_o, sleep_o}); end
    wakeup_i = 1'b0; tick(); tick();
    n_chk++; if (resume_o !== 1'b1 || sleep_cnt_o !== 16'd4) begin n_fail++; $display("FAIL wk_early_resume got=%b/%h exp=1/0004", resume_o, sleep_cnt_o); end
    tick();
  endtask

  task automatic test_saturation_and_reset;
    logic [15:0] exp_cnt [3];
    int bad;
    exp_cnt[0] = 16'hFFFE; exp_cnt[1] = 16'hFFFF; exp_cnt[2] = 16'hFFFF;
    force dut.sleep_cnt_q = 16'hFFFD;
    tick();
    release dut.sleep_cnt_q;
    tick();
    wakeup_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wfi_req = 1'b1; tick(); wfi_req = 1'b0; tick();
      n_chk++; if (sleep_cnt_o !== exp_cnt[k]) begin n_fail++; $display("FAIL sat_cnt_%0d got=%h exp=%h", k, sleep_cnt_o, exp_cnt[k]); end
      tick(); tick(); tick();
    end
    wakeup_i = 1'b0;
    outst_cnt = 4'd2;
    wfi_req = 1'b1; tick(); wfi_req = 1'b0; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_chk++; if ({state_o, stall_o, sleep_cnt_o} !== {2'd0, 1'b0, 16'd0}) begin n_fail++; $display("FAIL midrst_state got=%0d/%b/%h exp=0/0/0000", state_o, stall_o, sleep_cnt_o); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (resume_o !== 1'b0 || drain_tmo_o !== 1'b0) bad++;
      tick();
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL midrst_no_resume bad_cycles=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_nop();
    test_drain();
    test_simultaneous();
    test_sleep_exits();
    test_saturation_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
